child_resp_collector: RTL and testbench

Fan-in collector that gathers response words from up to ten child instances at one hierarchy level and forwards them, one at a time, to the parent level over a single valid/ready channel. It is the return path for the level's parent-to-children fan-out. The collector uses round-robin arbitration, a one-entry registered output stage and a transfer counter. It sits in each generated level wrapper, between the child instances and the parent's response port.

---
 rtl/child_resp_collector.sv | 116 +++++++++++
 tb/tb_child_resp_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/child_resp_collector.sv
// child_resp_collector
// Round-robin fan-in of child response words onto one valid/ready channel
// toward the parent. The output stage holds one registered word. A 16-bit
// counter tracks completed upstream handshakes.
// Optional feature: define COLLECTOR_SRC_TAG_EN to register the granted child
// index on up_src. Without it, up_src is tied to 0 and no register is built
// for it.
module child_resp_collector #(
  parameter int N_CHILD = 10,
  parameter int DATA_W  = 16,
  parameter int SRC_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CHILD-1:0]        child_valid,
  input  logic [N_CHILD*DATA_W-1:0] child_data,
  output logic [N_CHILD-1:0]        child_ready,
  output logic                      up_valid,
  output logic [DATA_W-1:0]         up_data,
  output logic [SRC_W-1:0]          up_src,
  input  logic                      up_ready,
  output logic [15:0]               xfer_cnt
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SRC_W-1:0]  r_ptr;
  logic [15:0]       r_cnt;

  logic              w_load_en;
  logic              w_any;
  logic              w_take;
  logic              w_drain;
  logic [SRC_W-1:0]  w_gnt;
  logic [SRC_W-1:0]  w_ptr_nxt;
  logic [DATA_W-1:0] w_word;

  // Reset gates the load path so no child sees ready while reset is held.
  assign w_load_en = (!r_valid || up_ready) && rst_n;
  assign w_take    = w_load_en && w_any;
  assign w_drain   = r_valid && up_ready;
  assign w_ptr_nxt = (w_gnt == SRC_W'(N_CHILD - 1)) ? '0 : w_gnt + SRC_W'(1);

  // Round-robin search: first valid child at or above r_ptr, wrapping at N_CHILD.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    w_gnt = '0;
    w_any = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      sum = {1'b0, r_ptr} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(N_CHILD)) sum = sum - (SRC_W+1)'(N_CHILD);
      idx = sum[SRC_W-1:0];
      if (!w_any && child_valid[idx]) begin
        w_any = 1'b1;
        w_gnt = idx;
      end
    end
  end

  // Select the granted child's word.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N_CHILD; k++) begin
      if (w_gnt == SRC_W'(k)) w_word = child_data[k*DATA_W +: DATA_W];
    end
  end

  // One-hot accept strobe to the granted child.
  always_comb begin
    child_ready = '0;
    if (w_take) child_ready[w_gnt] = 1'b1;
  end

  // Output register and priority pointer; a drain without a load empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
      r_ptr   <= w_ptr_nxt;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // Upstream handshake counter, free-running wrap at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_drain) r_cnt <= r_cnt + 16'd1;
  end

`ifdef COLLECTOR_SRC_TAG_EN
  logic [SRC_W-1:0] r_src;

  // Source tag follows the data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_src <= '0;
    else if (w_take) r_src <= w_gnt;
  end

  assign up_src = r_src;
`else
  assign up_src = '0;
`endif

  assign up_valid = r_valid;
  assign up_data  = r_data;
  assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_child_resp_collector.sv
// Bench for child_resp_collector: directed stimulus pushes expected words into
// a scoreboard queue; a negedge monitor pops one entry per upstream handshake.
module tb_child_resp_collector;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    child_valid;
  logic [N*DW-1:0] child_data;
  logic [N-1:0]    child_ready;
  logic            up_valid;
  logic [DW-1:0]   up_data;
  logic [SW-1:0]   up_src;
  logic            up_ready;
  logic [15:0]     xfer_cnt;

  typedef struct {
    logic [15:0] data;
    int          src;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  child_resp_collector #(.N_CHILD(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_src      (up_src),
    .up_ready    (up_ready),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_src(input int s);
`ifdef COLLECTOR_SRC_TAG_EN
    return 4'(s);
`else
    return 4'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] v);
    child_data[i*DW +: DW] = v;
  endtask

  task automatic push(input logic [15:0] d, input int s);
    exp_t e;
    e.data = d;
    e.src  = s;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    sb.delete();
    child_valid = '0;
    up_ready    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: each upstream handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && up_valid && up_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual_data=0x%0h expected=none t=%0t", up_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", 32'(up_data), 32'(e.data));
        chk("sb_src", 32'(up_src), 32'(exp_src(e.src)));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    child_valid = '1;
    child_data  = '0;
    up_ready    = 1'b1;
    #12;
    // Reset state, with every child requesting.
    chk("rst_up_valid", 32'(up_valid), 0);
    chk("rst_up_data", 32'(up_data), 0);
    chk("rst_up_src", 32'(up_src), 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
    chk("rst_child_ready", 32'(child_ready), 0);
    child_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single child.
    child_valid = 10'(1 << 3);
    set_word(3, 16'hA5A5);
    up_ready = 1'b1;
    push(16'hA5A5, 3);
    #1;
    chk("single_ready", 32'(child_ready), 32'(1 << 3));
    tick();
    child_valid = '0;
    chk("single_valid", 32'(up_valid), 1);
    chk("single_data", 32'(up_data), 32'hA5A5);
    chk("single_src", 32'(up_src), 32'(exp_src(3)));
    tick();
    chk("single_cnt", 32'(xfer_cnt), 1);
    chk("single_empty", 32'(up_valid), 0);

    // All children valid, fairness and full throughput.
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, 16'(i));
    for (int j = 0; j < 20; j++) push(16'(j % N), j % N);
    up_ready    = 1'b1;
    child_valid = '1;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("all_no_gap", 32'(up_valid), 1);
    end
    child_valid = '0;
    tick();
    chk("all_cnt20", 32'(xfer_cnt), 20);
    chk("all_empty", 32'(up_valid), 0);

    // Backpressure with children 2 and 7 (pointer is back at 0).
    up_ready = 1'b0;
    set_word(2, 16'h2222);
    set_word(7, 16'h7777);
    child_valid = 10'((1 << 2) | (1 << 7));
    push(16'h2222, 2);
    push(16'h7777, 7);
    #1;
    chk("bp_first_ready", 32'(child_ready), 32'(1 << 2));
    tick();
    child_valid = 10'(1 << 7);
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("bp_hold_valid", 32'(up_valid), 1);
      chk("bp_hold_data", 32'(up_data), 32'h2222);
      chk("bp_hold_src", 32'(up_src), 32'(exp_src(2)));
      chk("bp_no_ready", 32'(child_ready), 0);
      tick();
    end
    up_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(child_ready), 32'(1 << 7));
    tick();
    child_valid = '0;
    chk("bp_b2b_valid", 32'(up_valid), 1);
    chk("bp_b2b_data", 32'(up_data), 32'h7777);
    tick();
    chk("bp_cnt", 32'(xfer_cnt), 22);

    // Wrap priority: pointer is 8; grant 9, then 0 must beat 8.
    set_word(9, 16'h0909);
    set_word(0, 16'h1000);
    set_word(8, 16'h1008);
    child_valid = 10'(1 << 9);
    push(16'h0909, 9);
    push(16'h1000, 0);
    push(16'h1008, 8);
    #1;
    chk("wrap_g9", 32'(child_ready), 32'(1 << 9));
    tick();
    child_valid = 10'((1 << 0) | (1 << 8));
    #1;
    chk("wrap_g0", 32'(child_ready), 32'(1 << 0));
    tick();
    child_valid = 10'(1 << 8);
    #1;
    chk("wrap_g8", 32'(child_ready), 32'(1 << 8));
    tick();
    child_valid = '0;
    tick();
    chk("wrap_drained", 32'(up_valid), 0);

    // Reset mid-hold with a word held and count at 5.
    do_reset();
    set_word(1, 16'h0111);
    up_ready    = 1'b1;
    child_valid = 10'(1 << 1);
    for (int j = 0; j < 6; j++) push(16'h0111, 1);
    for (int j = 0; j < 6; j++) tick();
    child_valid = '0;
    up_ready    = 1'b0;
    chk("mid_pre_valid", 32'(up_valid), 1);
    chk("mid_pre_cnt", 32'(xfer_cnt), 5);
    #2;
    rst_n = 1'b0;
    sb.delete();
    child_valid = '1;
    #1;
    chk("mid_rst_valid", 32'(up_valid), 0);
    chk("mid_rst_cnt", 32'(xfer_cnt), 0);
    chk("mid_rst_src", 32'(up_src), 0);
    chk("mid_rst_ready", 32'(child_ready), 0);
    set_word(3, 16'h3333);
    set_word(5, 16'h5555);
    child_valid = 10'((1 << 3) | (1 << 5));
    up_ready    = 1'b1;
    rst_n       = 1'b1;
    push(16'h3333, 3);
    push(16'h5555, 5);
    #1;
    chk("post_rst_lowest", 32'(child_ready), 32'(1 << 3));
    tick();
    child_valid = 10'(1 << 5);
    tick();
    child_valid = '0;
    tick();
    chk("post_rst_cnt", 32'(xfer_cnt), 2);

    // Counter wrap: 65536 handshakes from a cleared counter.
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, 16'(16'hC000 + i));
    for (int j = 0; j < 65536; j++) push(16'(16'hC000 + (j % N)), j % N);
    up_ready    = 1'b1;
    child_valid = '1;
    for (int j = 0; j < 65536; j++) tick();
    child_valid = '0;
    chk("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    tick();
    chk("cnt_wrap", 32'(xfer_cnt), 0);
    chk("cnt_empty", 32'(up_valid), 0);

    tick();
    chk("sb_left", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
